// File: rtl/sys_time_div_arbiter.sv
// Round-robin front end for one shared pipelined remainder divider.
// Tags each issue so remainders return to the right requester; zero divisors get a defined result.
module sys_time_div_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 16,
  parameter int DIV_LATENCY = 20
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [N_REQ-1:0]       REQ_VALID,
  input  logic [64*N_REQ-1:0]    REQ_DIVIDEND,
  input  logic [WIDTH*N_REQ-1:0] REQ_DIVISOR,
  output logic [N_REQ-1:0]       REQ_ACK,
  output logic [N_REQ-1:0]       RSP_VALID,
  output logic [WIDTH-1:0]       RSP_REM,
  output logic                   RSP_DIV0,
  output logic [63:0]            DIV_DIVIDEND,
  output logic [WIDTH-1:0]       DIV_DIVISOR,
  output logic                   DIV_IN_VALID,
  input  logic [WIDTH-1:0]       DIV_REM,
  input  logic                   DIV_OUT_VALID,
  output logic                   ERR
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(N_REQ + 1);
  localparam int DW = $clog2(DIV_LATENCY + 1);
  localparam logic [IW:0]   NREQ_W       = (IW+1)'(N_REQ);
  localparam logic [IW-1:0] LAST_ID      = IW'(N_REQ - 1);
  localparam logic [DW-1:0] DISCARD_INIT = DW'(DIV_LATENCY);

  logic [1:0]       rst_sync;
  logic             rst_n_int;
  logic [N_REQ-1:0] busy, busy_nxt, eligible;
  logic [IW-1:0]    rr_ptr, rr_nxt, win_id;
  logic             grant, pop, stray;
  logic [63:0]      win_dividend;
  logic [WIDTH-1:0] win_divisor;
  logic [IW-1:0]    tag_id [N_REQ];
  logic             tag_d0 [N_REQ];
  logic [IW-1:0]    wr_ptr, rd_ptr, rsp_id;
  logic             rsp_d0;
  logic [CW-1:0]    count;
  logic [DW-1:0]    discard;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == LAST_ID) ? '0 : p + IW'(1);
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  // Search from rr_ptr upward with wrap; first eligible requester wins.
  always_comb begin
    logic [IW:0] cand;
    eligible = REQ_VALID & ~busy;
    grant    = 1'b0;
    win_id   = '0;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!grant && eligible[cand[IW-1:0]]) begin
        grant  = 1'b1;
        win_id = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    win_dividend = REQ_DIVIDEND[int'(win_id)*64 +: 64];
    win_divisor  = REQ_DIVISOR[int'(win_id)*WIDTH +: WIDTH];
    rr_nxt       = ptr_inc(win_id);
    rsp_id       = tag_id[rd_ptr];
    rsp_d0       = tag_d0[rd_ptr];
    // Outputs during the post-reset discard window belong to pre-reset issues.
    pop          = DIV_OUT_VALID && (discard == '0) && (count != '0);
    stray        = DIV_OUT_VALID && (discard == '0) && (count == '0);
    busy_nxt     = busy;
    if (pop)   busy_nxt[rsp_id] = 1'b0;
    if (grant) busy_nxt[win_id] = 1'b1;
  end

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      REQ_ACK      <= '0;
      RSP_VALID    <= '0;
      RSP_REM      <= '0;
      RSP_DIV0     <= 1'b0;
      DIV_DIVIDEND <= '0;
      DIV_DIVISOR  <= '0;
      DIV_IN_VALID <= 1'b0;
      ERR          <= 1'b0;
      busy         <= '0;
      rr_ptr       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      discard      <= DISCARD_INIT;
      for (int i = 0; i < N_REQ; i++) begin
        tag_id[i] <= '0;
        tag_d0[i] <= 1'b0;
      end
    end else begin
      REQ_ACK      <= '0;
      RSP_VALID    <= '0;
      DIV_IN_VALID <= grant;
      busy         <= busy_nxt;
      if (grant) begin
        REQ_ACK[win_id] <= 1'b1;
        DIV_DIVIDEND    <= win_dividend;
        DIV_DIVISOR     <= win_divisor;
        tag_id[wr_ptr]  <= win_id;
        tag_d0[wr_ptr]  <= (win_divisor == '0);
        wr_ptr          <= ptr_inc(wr_ptr);
        rr_ptr          <= rr_nxt;
      end
      if (pop) begin
        RSP_VALID[rsp_id] <= 1'b1;
        RSP_REM           <= rsp_d0 ? '0 : DIV_REM;
        RSP_DIV0          <= rsp_d0;
        rd_ptr            <= ptr_inc(rd_ptr);
      end
      case ({grant, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (discard != '0) discard <= discard - DW'(1);
      if (stray) ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sys_time_div_arbiter.sv
// Directed bench for sys_time_div_arbiter with a fixed-latency divider model.
module tb_sys_time_div_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 20;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic [N-1:0]   REQ_VALID = '0;
  logic [64*N-1:0] REQ_DIVIDEND = '0;
  logic [W*N-1:0] REQ_DIVISOR = '0;
  logic [N-1:0]   REQ_ACK, RSP_VALID;
  logic [W-1:0]   RSP_REM, DIV_DIVISOR, DIV_REM;
  logic           RSP_DIV0, DIV_IN_VALID, DIV_OUT_VALID, ERR;
  logic [63:0]    DIV_DIVIDEND;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  dov_cnt = 0;
  logic spur = 1'b0;

  bit          dv [L];
  logic [W-1:0] dr [L];

  sys_time_div_arbiter #(.N_REQ(N), .WIDTH(W), .DIV_LATENCY(L)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_DIVIDEND(REQ_DIVIDEND),
    .REQ_DIVISOR(REQ_DIVISOR), .REQ_ACK(REQ_ACK), .RSP_VALID(RSP_VALID),
    .RSP_REM(RSP_REM), .RSP_DIV0(RSP_DIV0), .DIV_DIVIDEND(DIV_DIVIDEND),
    .DIV_DIVISOR(DIV_DIVISOR), .DIV_IN_VALID(DIV_IN_VALID), .DIV_REM(DIV_REM),
    .DIV_OUT_VALID(DIV_OUT_VALID), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Divider model: not reset, so results issued before a reset still emerge.
  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    dv[0] <= DIV_IN_VALID;
    dr[0] <= (DIV_DIVISOR == '0) ? 16'hBEEF : 16'(DIV_DIVIDEND % {48'd0, DIV_DIVISOR});
    for (int k = 1; k < L; k++) begin
      dv[k] <= dv[k-1];
      dr[k] <= dr[k-1];
    end
    if (DIV_OUT_VALID) dov_cnt <= dov_cnt + 1;
  end
  assign DIV_OUT_VALID = dv[L-1] | spur;
  assign DIV_REM       = dr[L-1];

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] dd, input logic [W-1:0] ds);
    REQ_DIVIDEND[i*64 +: 64] = dd;
    REQ_DIVISOR[i*W +: W]    = ds;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    REQ_VALID = '0;
    repeat (3) step();
    checks++; if (REQ_ACK !== 4'b0)   begin failures++; $display("FAIL reset_ack: got %b expected 0000", REQ_ACK); end
    checks++; if (RSP_VALID !== 4'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0000", RSP_VALID); end
    checks++; if (RSP_REM !== 16'd0)  begin failures++; $display("FAIL reset_rsp_rem: got %0h expected 0", RSP_REM); end
    checks++; if (RSP_DIV0 !== 1'b0)  begin failures++; $display("FAIL reset_rsp_div0: got %b expected 0", RSP_DIV0); end
    checks++; if (DIV_IN_VALID !== 1'b0) begin failures++; $display("FAIL reset_div_in_valid: got %b expected 0", DIV_IN_VALID); end
    checks++; if (DIV_DIVIDEND !== 64'd0) begin failures++; $display("FAIL reset_div_dividend: got %0h expected 0", DIV_DIVIDEND); end
    checks++; if (DIV_DIVISOR !== 16'd0)  begin failures++; $display("FAIL reset_div_divisor: got %0h expected 0", DIV_DIVISOR); end
    checks++; if (ERR !== 1'b0)       begin failures++; $display("FAIL reset_err: got %b expected 0", ERR); end
    RST_N = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_contention;
    logic [W-1:0] exp_rem [4];
    int n;
    exp_rem = '{16'd2, 16'd1, 16'd7, 16'd255};
    set_req(0, 64'd50000, 16'd13);
    set_req(1, 64'd100, 16'd9);
    set_req(2, 64'd777, 16'd10);
    set_req(3, 64'd65535, 16'd256);
    REQ_VALID = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (REQ_ACK !== 4'(1 << k)) begin failures++; $display("FAIL contention_ack%0d: got %b expected %b", k, REQ_ACK, 4'(1 << k)); end
      REQ_VALID[k] = 1'b0;
    end
    n = 0;
    while (RSP_VALID == '0 && n < 40) begin step(); n++; end
    checks++;
    if (n !== L - 2) begin failures++; $display("FAIL contention_latency: got %0d cycles expected %0d", n, L - 2); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (RSP_VALID !== 4'(1 << k) || RSP_REM !== exp_rem[k] || RSP_DIV0 !== 1'b0) begin
        failures++;
        $display("FAIL contention_rsp%0d: got valid=%b rem=%0d div0=%b expected valid=%b rem=%0d div0=0",
                 k, RSP_VALID, RSP_REM, RSP_DIV0, 4'(1 << k), exp_rem[k]);
      end
      step();
    end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp_ack [4];
    logic [W-1:0] exp_rem [4];
    int n;
    exp_ack = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_rem = '{16'd2, 16'd3, 16'd2, 16'd1};
    set_req(0, 64'd10, 16'd3);
    set_req(1, 64'd20, 16'd6);
    set_req(2, 64'd45, 16'd7);
    set_req(3, 64'd30, 16'd7);
    REQ_VALID = 4'b0010;
    step();
    checks++;
    if (REQ_ACK !== exp_ack[0]) begin failures++; $display("FAIL rr_ack0: got %b expected %b", REQ_ACK, exp_ack[0]); end
    REQ_VALID = 4'b1101;
    for (int k = 1; k < 4; k++) begin
      step();
      checks++;
      if (REQ_ACK !== exp_ack[k]) begin failures++; $display("FAIL rr_ack%0d: got %b expected %b", k, REQ_ACK, exp_ack[k]); end
      REQ_VALID = REQ_VALID & ~exp_ack[k];
    end
    n = 0;
    while (RSP_VALID == '0 && n < 40) begin step(); n++; end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (RSP_VALID !== exp_ack[k] || RSP_REM !== exp_rem[k]) begin
        failures++;
        $display("FAIL rr_rsp%0d: got valid=%b rem=%0d expected valid=%b rem=%0d", k, RSP_VALID, RSP_REM, exp_ack[k], exp_rem[k]);
      end
      step();
    end
  endtask

  task automatic test_single;
    int n;
    set_req(0, 64'd1000, 16'd7);
    REQ_VALID = 4'b0001;
    step();
    checks++;
    if (REQ_ACK !== 4'b0001 || DIV_IN_VALID !== 1'b1) begin
      failures++; $display("FAIL single_ack: got ack=%b in_valid=%b expected ack=0001 in_valid=1", REQ_ACK, DIV_IN_VALID);
    end
    checks++;
    if (DIV_DIVIDEND !== 64'd1000 || DIV_DIVISOR !== 16'd7) begin
      failures++; $display("FAIL single_issue: got %0d/%0d expected 1000/7", DIV_DIVIDEND, DIV_DIVISOR);
    end
    REQ_VALID = 4'b0000;
    set_req(0, 64'd999, 16'd5);
    step();
    checks++;
    if (DIV_IN_VALID !== 1'b0) begin failures++; $display("FAIL single_no_reissue: got %b expected 0", DIV_IN_VALID); end
    n = 1;
    while (RSP_VALID == '0 && n < 40) begin step(); n++; end
    checks++;
    if (n !== L + 1) begin failures++; $display("FAIL single_latency: got %0d cycles after ack expected %0d", n, L + 1); end
    checks++;
    if (RSP_VALID !== 4'b0001 || RSP_REM !== 16'd6 || RSP_DIV0 !== 1'b0) begin
      failures++; $display("FAIL single_rsp: got valid=%b rem=%0d div0=%b expected 0001/6/0", RSP_VALID, RSP_REM, RSP_DIV0);
    end
    step();
    checks++;
    if (RSP_VALID !== 4'b0000 || RSP_REM !== 16'd6) begin
      failures++; $display("FAIL single_hold: got valid=%b rem=%0d expected 0000/6", RSP_VALID, RSP_REM);
    end
  endtask

  task automatic test_div0;
    bit got1 = 0, got2 = 0;
    int n = 0;
    set_req(2, 64'd12345, 16'd0);
    set_req(1, 64'd100, 16'd9);
    REQ_VALID = 4'b0110;
    while (!(got1 && got2) && n < 60) begin
      step(); n++;
      if (REQ_ACK[2]) begin
        checks++;
        if (DIV_IN_VALID !== 1'b1 || DIV_DIVISOR !== 16'd0) begin
          failures++; $display("FAIL div0_issue: got in_valid=%b divisor=%0d expected 1/0", DIV_IN_VALID, DIV_DIVISOR);
        end
      end
      REQ_VALID = REQ_VALID & ~REQ_ACK;
      if (RSP_VALID[2]) begin
        got2 = 1; checks++;
        if (RSP_REM !== 16'd0 || RSP_DIV0 !== 1'b1) begin
          failures++; $display("FAIL div0_rsp: got rem=%0h div0=%b expected 0/1", RSP_REM, RSP_DIV0);
        end
      end
      if (RSP_VALID[1]) begin
        got1 = 1; checks++;
        if (RSP_REM !== 16'd1 || RSP_DIV0 !== 1'b0) begin
          failures++; $display("FAIL div0_neighbour_rsp: got rem=%0d div0=%b expected 1/0", RSP_REM, RSP_DIV0);
        end
      end
    end
    checks++;
    if (!(got1 && got2)) begin failures++; $display("FAIL div0_timeout: got req1=%0d req2=%0d expected both", got1, got2); end
    REQ_VALID = '0;
    repeat (2) step();
  endtask

  task automatic test_back_to_back;
    logic [63:0] cur;
    logic [W-1:0] q [$];
    logic [W-1:0] e;
    int acks = 0, rsps = 0, last_ack = -1, n = 0;
    cur = (64'h0000_0123_4567_89AB + 64'(cyc)) >> 2;
    set_req(0, cur, 16'd4000);
    REQ_VALID = 4'b0001;
    while (rsps < 4 && n < 200) begin
      step(); n++;
      if (REQ_ACK[0]) begin
        checks++;
        if (DIV_DIVIDEND !== cur) begin failures++; $display("FAIL b2b_dividend: got %0h expected %0h", DIV_DIVIDEND, cur); end
        if (last_ack >= 0) begin
          checks++;
          if (n - last_ack != L + 2) begin failures++; $display("FAIL b2b_period: got %0d expected %0d", n - last_ack, L + 2); end
        end
        last_ack = n;
        q.push_back(16'(cur % 64'd4000));
        acks++;
        if (acks == 4) REQ_VALID = '0;
      end
      if (RSP_VALID[0]) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL b2b_extra_rsp: got rem=%0d expected no response", RSP_REM);
        end else begin
          e = q.pop_front();
          if (RSP_REM !== e || RSP_DIV0 !== 1'b0) begin
            failures++; $display("FAIL b2b_rem: got %0d div0=%b expected %0d div0=0", RSP_REM, RSP_DIV0, e);
          end
        end
        rsps++;
      end
      cur = (64'h0000_0123_4567_89AB + 64'(cyc)) >> 2;
      set_req(0, cur, 16'd4000);
    end
    checks++;
    if (rsps != 4) begin failures++; $display("FAIL b2b_timeout: got %0d responses expected 4", rsps); end
    REQ_VALID = '0;
    step();
  endtask

  task automatic test_random;
    bit pend [N];
    bit outs [N];
    int wait_c [N];
    logic [63:0] r_dd [N];
    logic [W-1:0] r_ds [N];
    logic [W-1:0] exp_rem [N];
    bit exp_d0 [N];
    bit left = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; outs[i] = 0; wait_c[i] = 0; end
    for (int c = 0; c < 100 + L + 10; c++) begin
      step();
      checks++;
      if ($countones(REQ_ACK) > 1) begin failures++; $display("FAIL rand_multi_ack: got %b expected at most one", REQ_ACK); end
      for (int i = 0; i < N; i++) begin
        if (REQ_ACK[i]) begin
          checks++;
          if (!pend[i]) begin
            failures++; $display("FAIL rand_unexpected_ack%0d: got ack expected none", i);
          end else begin
            if (wait_c[i] > N - 1) begin failures++; $display("FAIL rand_starve%0d: got %0d wait cycles expected <= %0d", i, wait_c[i], N - 1); end
            pend[i] = 0; outs[i] = 1; REQ_VALID[i] = 1'b0;
            exp_d0[i]  = (r_ds[i] == '0);
            exp_rem[i] = exp_d0[i] ? 16'd0 : 16'(r_dd[i] % {48'd0, r_ds[i]});
          end
        end else if (pend[i]) begin
          wait_c[i]++;
        end
        if (RSP_VALID[i]) begin
          checks++;
          if (!outs[i]) begin
            failures++; $display("FAIL rand_unexpected_rsp%0d: got rem=%0d expected none", i, RSP_REM);
          end else if ({RSP_DIV0, RSP_REM} !== {exp_d0[i], exp_rem[i]}) begin
            failures++; $display("FAIL rand_rsp%0d: got rem=%0d div0=%b expected rem=%0d div0=%b", i, RSP_REM, RSP_DIV0, exp_rem[i], exp_d0[i]);
          end
          outs[i] = 0;
        end
        if (c < 100 && !pend[i] && !outs[i] && $urandom_range(0, 2) == 0) begin
          r_dd[i] = {$urandom, $urandom};
          r_ds[i] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
          set_req(i, r_dd[i], r_ds[i]);
          REQ_VALID[i] = 1'b1; pend[i] = 1; wait_c[i] = 0;
        end
      end
    end
    for (int i = 0; i < N; i++) if (pend[i] || outs[i]) left = 1;
    checks++;
    if (left) begin failures++; $display("FAIL rand_drain: got requests still open expected none"); end
    REQ_VALID = '0;
  endtask

  task automatic test_reset_midflight;
    int dov0, n, bad = 0;
    set_req(0, 64'd111, 16'd10);
    set_req(1, 64'd222, 16'd10);
    set_req(2, 64'd333, 16'd10);
    REQ_VALID = 4'b0111;
    n = 0;
    while (REQ_VALID != '0 && n < 10) begin step(); n++; REQ_VALID = REQ_VALID & ~REQ_ACK; end
    repeat (4) step();
    dov0 = dov_cnt;
    RST_N = 1'b0;
    step();
    checks++;
    if (REQ_ACK !== 4'b0 || RSP_VALID !== 4'b0 || DIV_IN_VALID !== 1'b0 || busy_probe() !== 1'b1) begin
      failures++; $display("FAIL midreset_outputs: got ack=%b rsp=%b in_valid=%b expected all zero", REQ_ACK, RSP_VALID, DIV_IN_VALID);
    end
    step();
    RST_N = 1'b1;
    for (int c = 0; c < L + 10; c++) begin
      step();
      if (RSP_VALID != '0 || ERR != 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL midreset_flush: got %0d cycles with rsp or err expected 0", bad); end
    checks++;
    if (dov_cnt - dov0 != 3) begin failures++; $display("FAIL midreset_div_outputs: got %0d expected 3", dov_cnt - dov0); end
    set_req(1, 64'd500, 16'd7);
    REQ_VALID = 4'b0010;
    n = 0;
    while (RSP_VALID == '0 && n < 40) begin step(); n++; REQ_VALID = REQ_VALID & ~REQ_ACK; end
    checks++;
    if (RSP_VALID !== 4'b0010 || RSP_REM !== 16'd3 || ERR !== 1'b0) begin
      failures++; $display("FAIL midreset_new_req: got valid=%b rem=%0d err=%b expected 0010/3/0", RSP_VALID, RSP_REM, ERR);
    end
    REQ_VALID = '0;
    step();
  endtask

  function automatic logic busy_probe();
    return 1'b1;
  endfunction

  task automatic test_spurious;
    checks++;
    if (ERR !== 1'b0) begin failures++; $display("FAIL spur_pre_err: got %b expected 0", ERR); end
    spur = 1'b1;
    step();
    spur = 1'b0;
    checks++;
    if (ERR !== 1'b1 || RSP_VALID !== 4'b0) begin
      failures++; $display("FAIL spur_err: got err=%b rsp=%b expected 1/0000", ERR, RSP_VALID);
    end
    repeat (5) step();
    checks++;
    if (ERR !== 1'b1) begin failures++; $display("FAIL spur_sticky: got %b expected 1", ERR); end
    RST_N = 1'b0;
    step();
    checks++;
    if (ERR !== 1'b0) begin failures++; $display("FAIL spur_reset_clear: got %b expected 0", ERR); end
    RST_N = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_round_robin();
    test_single();
    test_div0();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    repeat (L + 5) step();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
